// File: rtl/pi_loop_filter.sv
// Early/late phase-detector loop filter that emits one-cycle advance/retard pulses.
// Random-walk or PI counter drive, saturating integral (frequency word), holdoff and lock.
module pi_loop_filter #(
    parameter int COUNT_W     = 12,
    parameter int THRESHOLD   = 64,
    parameter int INT_W       = 16,
    parameter int KP          = 4,
    parameter int KI          = 1,
    parameter int INT_SHIFT   = 4,
    parameter int HOLDOFF     = 8,
    parameter int LOCK_CYCLES = 1024
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    clear_i,
    input  logic                    mode_i,
    input  logic                    forwarding_i,
    input  logic                    slowing_i,
    output logic                    positiveShift_o,
    output logic                    negativeShift_o,
    output logic signed [INT_W-1:0] freq_word_o,
    output logic                    lock_o
);

    // Arithmetic runs two bits wider than either state register so the threshold
    // compare stays exact even when a large integral term pushes past the counter range.
    localparam int SW   = ((COUNT_W > INT_W) ? COUNT_W : INT_W) + 2;
    localparam int HO_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
    localparam int LK_W = $clog2(LOCK_CYCLES + 1);

    localparam logic signed [SW-1:0] ONE_S    = SW'(1);
    localparam logic signed [SW-1:0] KP_S     = SW'(KP);
    localparam logic signed [SW-1:0] KI_S     = SW'(KI);
    localparam logic signed [SW-1:0] TH_S     = SW'(THRESHOLD);
    localparam logic signed [SW-1:0] NEG_TH_S = -TH_S;
    localparam logic signed [SW-1:0] INT_MAX  = SW'((64'sd1 <<< (INT_W - 1)) - 64'sd1);
    localparam logic signed [SW-1:0] INT_MIN  = -INT_MAX;
    localparam logic [HO_W-1:0]      HO_INIT  = HO_W'(HOLDOFF);
    localparam logic [LK_W-1:0]      LK_MAX   = LK_W'(LOCK_CYCLES);

    typedef enum logic [1:0] {
        DIR_NONE,
        DIR_UP,
        DIR_DOWN
    } dir_e;

    logic signed [COUNT_W-1:0] cnt_q, cnt_d;
    logic signed [INT_W-1:0]   int_q, int_d;
    logic [HO_W-1:0]           ho_q, ho_d;
    logic [LK_W-1:0]           lock_cnt_q, lock_cnt_d;
    logic                      pos_q, pos_d;
    logic                      neg_q, neg_d;

    dir_e                      dir;
    logic signed [SW-1:0]      int_ext;
    logic signed [SW-1:0]      int_term;
    logic signed [SW-1:0]      int_sum;
    logic signed [SW-1:0]      cnt_ext;
    logic signed [SW-1:0]      step;
    logic signed [SW-1:0]      cnt_next;

    always_comb begin
        dir = DIR_NONE;
        if (forwarding_i && !slowing_i) begin
            dir = DIR_UP;
        end else if (slowing_i && !forwarding_i) begin
            dir = DIR_DOWN;
        end
    end

    // The counter step always uses the integral value from before this edge's update.
    always_comb begin
        int_ext  = {{(SW-INT_W){int_q[INT_W-1]}}, int_q};
        cnt_ext  = {{(SW-COUNT_W){cnt_q[COUNT_W-1]}}, cnt_q};
        int_term = int_ext >>> INT_SHIFT;

        int_sum = int_ext;
        case (dir)
            DIR_UP:   int_sum = int_ext + KI_S;
            DIR_DOWN: int_sum = int_ext - KI_S;
            default:  ;
        endcase

        step = '0;
        if (mode_i) begin
            case (dir)
                DIR_UP:   step = int_term + KP_S;
                DIR_DOWN: step = int_term - KP_S;
                default:  step = int_term;
            endcase
        end else begin
            case (dir)
                DIR_UP:   step = ONE_S;
                DIR_DOWN: step = -ONE_S;
                default:  step = '0;
            endcase
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        cnt_next   = cnt_ext + step;
        cnt_d      = cnt_q;
        ho_d       = ho_q;
        pos_d      = 1'b0;
        neg_d      = 1'b0;
        int_d      = '0;
        lock_cnt_d = lock_cnt_q;

        if (clear_i) begin
            cnt_d = '0;
            ho_d  = '0;
        end else if (ho_q != '0) begin
            // Clamping during holdoff leaves a saturated counter ready to fire once it ends.
            if (cnt_next > TH_S) begin
                cnt_d = TH_S[COUNT_W-1:0];
            end else if (cnt_next < NEG_TH_S) begin
                cnt_d = NEG_TH_S[COUNT_W-1:0];
            end else begin
                cnt_d = cnt_next[COUNT_W-1:0];
            end
            ho_d = ho_q - HO_W'(1);
        end else if (cnt_next >= TH_S) begin
            pos_d = 1'b1;
            cnt_d = '0;
            ho_d  = HO_INIT;
        end else if (cnt_next <= NEG_TH_S) begin
            neg_d = 1'b1;
            cnt_d = '0;
            ho_d  = HO_INIT;
        end else begin
            cnt_d = cnt_next[COUNT_W-1:0];
        end

        if (!clear_i && mode_i) begin
            if (int_sum > INT_MAX) begin
                int_d = INT_MAX[INT_W-1:0];
            end else if (int_sum < INT_MIN) begin
                int_d = INT_MIN[INT_W-1:0];
            end else begin
                int_d = int_sum[INT_W-1:0];
            end
        end

        if (clear_i || pos_d || neg_d) begin
            lock_cnt_d = '0;
        end else if (lock_cnt_q != LK_MAX) begin
            lock_cnt_d = lock_cnt_q + LK_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q      <= '0;
            int_q      <= '0;
            ho_q       <= '0;
            lock_cnt_q <= '0;
            pos_q      <= 1'b0;
            neg_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            cnt_q      <= cnt_d;
            int_q      <= int_d;
            ho_q       <= ho_d;
            lock_cnt_q <= lock_cnt_d;
            pos_q      <= pos_d;
            neg_q      <= neg_d;
        end
    end

    assign positiveShift_o = pos_q;
    assign negativeShift_o = neg_q;
    assign freq_word_o     = int_q;
    assign lock_o          = (lock_cnt_q == LK_MAX);

endmodule

// File: tb/tb_pi_loop_filter.sv
// Self-checking bench for pi_loop_filter: a default instance and a THRESHOLD=4 instance
// share stimulus and are checked against an integer model plus scenario-specific timing.
module tb_pi_loop_filter;

    localparam int INT_W       = 16;
    localparam int KP          = 4;
    localparam int KI          = 1;
    localparam int INT_SHIFT   = 4;
    localparam int HOLDOFF     = 8;
    localparam int LOCK_CYCLES = 1024;
    localparam int TH_BIG      = 64;
    localparam int TH_SMALL    = 4;
    localparam int INT_LIM     = 32767;

    typedef struct {
        int cnt;
        int integ;
        int ho;
        int lock_cnt;
        bit pos;
        bit neg;
    } model_t;

    logic clk_i = 1'b0;
    logic reset_i, clear_i, mode_i, forwarding_i, slowing_i;
    logic pos_b, neg_b, lock_b, pos_s, neg_s, lock_s;
    logic [INT_W-1:0] freq_b, freq_s;

    int n_checks = 0;
    int n_fail   = 0;
    model_t m_big, m_small;

    wire [37:0] obs_all = {pos_b, neg_b, lock_b, freq_b, pos_s, neg_s, lock_s, freq_s};

    always #5 clk_i = ~clk_i;

    pi_loop_filter dut_big (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .clear_i        (clear_i),
        .mode_i         (mode_i),
        .forwarding_i   (forwarding_i),
        .slowing_i      (slowing_i),
        .positiveShift_o(pos_b),
        .negativeShift_o(neg_b),
        .freq_word_o    (freq_b),
        .lock_o         (lock_b)
    );

    pi_loop_filter #(.THRESHOLD(TH_SMALL)) dut_small (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .clear_i        (clear_i),
        .mode_i         (mode_i),
        .forwarding_i   (forwarding_i),
        .slowing_i      (slowing_i),
        .positiveShift_o(pos_s),
        .negativeShift_o(neg_s),
        .freq_word_o    (freq_s),
        .lock_o         (lock_s)
    );

    function automatic model_t zero_model();
        model_t z;
        z.cnt = 0; z.integ = 0; z.ho = 0; z.lock_cnt = 0; z.pos = 0; z.neg = 0;
        return z;
    endfunction

    // One clock edge of the loop filter, written directly from the behavioural rules.
    function automatic model_t model_next(model_t s, bit clr, bit mode, bit fwd, bit slw, int th);
        model_t n;
        int d, step, nxt;
        if (clr) return zero_model();
        n = s;
        n.pos = 0;
        n.neg = 0;
        d = (fwd == slw) ? 0 : (fwd ? 1 : -1);
        step = mode ? (d * KP + (s.integ >>> INT_SHIFT)) : d;
        nxt = s.cnt + step;
        if (s.ho > 0) begin
            n.cnt = (nxt > th) ? th : ((nxt < -th) ? -th : nxt);
            n.ho  = s.ho - 1;
        end else if (nxt >= th) begin
            n.pos = 1; n.cnt = 0; n.ho = HOLDOFF;
        end else if (nxt <= -th) begin
            n.neg = 1; n.cnt = 0; n.ho = HOLDOFF;
        end else begin
            n.cnt = nxt;
        end
        if (mode) begin
            n.integ = s.integ + d * KI;
            if (n.integ > INT_LIM) n.integ = INT_LIM;
            if (n.integ < -INT_LIM) n.integ = -INT_LIM;
        end else begin
            n.integ = 0;
        end
        if (n.pos || n.neg) n.lock_cnt = 0;
        else n.lock_cnt = (s.lock_cnt < LOCK_CYCLES) ? s.lock_cnt + 1 : LOCK_CYCLES;
        return n;
    endfunction

    function automatic logic [18:0] exp_vec(model_t m);
        logic [INT_W-1:0] f;
        f = INT_W'(m.integ);
        return {m.pos, m.neg, (m.lock_cnt == LOCK_CYCLES), f};
    endfunction

    function automatic logic [37:0] exp_all();
        return {exp_vec(m_big), exp_vec(m_small)};
    endfunction

    task automatic tick(input bit clr, input bit mode, input bit fwd, input bit slw);
        clear_i      = clr;
        mode_i       = mode;
        forwarding_i = fwd;
        slowing_i    = slw;
        @(posedge clk_i);
        m_big   = model_next(m_big, clr, mode, fwd, slw, TH_BIG);
        m_small = model_next(m_small, clr, mode, fwd, slw, TH_SMALL);
        #1;
    endtask

    task automatic test_reset();
        reset_i = 1'b1; clear_i = 1'b0; mode_i = 1'b0; forwarding_i = 1'b0; slowing_i = 1'b0;
        repeat (20) @(posedge clk_i);
        #1;
        m_big = zero_model();
        m_small = zero_model();
        n_checks++;
        if (obs_all !== 38'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0", obs_all);
        end
        reset_i = 1'b0;
        for (int i = 1; i <= LOCK_CYCLES; i++) begin
            tick(0, 0, 0, 0);
            n_checks++;
            if ({lock_b, lock_s} !== {2{i == LOCK_CYCLES}}) begin
                n_fail++;
                $display("FAIL reset_lock_time tick %0d: got %b%b want %0d", i, lock_b, lock_s, i == LOCK_CYCLES);
            end
            n_checks++;
            if (obs_all !== exp_all()) begin
                n_fail++;
                $display("FAIL model_idle tick %0d: got %h want %h", i, obs_all, exp_all());
            end
        end
    endtask

    task automatic test_mode0_forwarding();
        logic [18:0] want;
        for (int i = 1; i <= 200; i++) begin
            tick(0, 0, 1, 0);
            want = {(i % TH_BIG == 0), 1'b0, (i < TH_BIG), 16'd0};
            n_checks++;
            if ({pos_b, neg_b, lock_b, freq_b} !== want) begin
                n_fail++;
                $display("FAIL mode0_pulse_train tick %0d: got %h want %h", i, {pos_b, neg_b, lock_b, freq_b}, want);
            end
            n_checks++;
            if (obs_all !== exp_all()) begin
                n_fail++;
                $display("FAIL model_mode0 tick %0d: got %h want %h", i, obs_all, exp_all());
            end
        end
    endtask

    task automatic test_holdoff();
        tick(1, 0, 0, 0);
        for (int i = 1; i <= 30; i++) begin
            tick(0, 0, 0, 1);
            n_checks++;
            if ({pos_s, neg_s} !== {1'b0, (i == 4 || i == 13 || i == 22)}) begin
                n_fail++;
                $display("FAIL holdoff_spacing tick %0d: got pos=%b neg=%b", i, pos_s, neg_s);
            end
            n_checks++;
            if (obs_all !== exp_all()) begin
                n_fail++;
                $display("FAIL model_holdoff tick %0d: got %h want %h", i, obs_all, exp_all());
            end
        end
    endtask

    task automatic test_pi_ramp();
        int pulses[$];
        tick(1, 0, 0, 0);
        for (int i = 1; i <= 100; i++) begin
            tick(0, 1, 1, 0);
            if (pos_b === 1'b1) pulses.push_back(i);
            n_checks++;
            if (freq_b !== 16'(i)) begin
                n_fail++;
                $display("FAIL pi_freq_ramp tick %0d: got %0d want %0d", i, freq_b, i);
            end
            n_checks++;
            if (obs_all !== exp_all()) begin
                n_fail++;
                $display("FAIL model_pi tick %0d: got %h want %h", i, obs_all, exp_all());
            end
        end
        n_checks++;
        if (pulses.size() < 3 || pulses[0] != 16 || (pulses[1] - pulses[0]) >= 16 ||
            (pulses[2] - pulses[1]) > (pulses[1] - pulses[0])) begin
            n_fail++;
            $display("FAIL pi_spacing: got %0d pulses, first at %p, want first at 16 with shrinking gaps",
                     pulses.size(), pulses);
        end
    endtask

    task automatic test_both_inputs();
        int pulses[$];
        bit ok;
        tick(1, 0, 0, 0);
        for (int i = 1; i <= 32; i++) tick(0, 1, 1, 0);
        for (int i = 1; i <= 100; i++) begin
            tick(0, 1, 1, 1);
            if (pos_b === 1'b1 || neg_b === 1'b1) pulses.push_back(i);
            n_checks++;
            if (freq_b !== 16'd32) begin
                n_fail++;
                $display("FAIL both_int_hold tick %0d: got %0d want 32", i, freq_b);
            end
            n_checks++;
            if (obs_all !== exp_all()) begin
                n_fail++;
                $display("FAIL model_both tick %0d: got %h want %h", i, obs_all, exp_all());
            end
        end
        ok = (pulses.size() >= 3);
        for (int k = 1; k < pulses.size(); k++) if (pulses[k] - pulses[k-1] != 32) ok = 0;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL both_spacing: got pulse ticks %p want 3+ pulses 32 apart", pulses);
        end
    endtask

    task automatic test_clear();
        tick(1, 0, 0, 0);
        for (int i = 1; i <= 50; i++) tick(0, 1, 1, 0);
        tick(1, 0, 1, 0);
        n_checks++;
        if (obs_all !== 38'd0) begin
            n_fail++;
            $display("FAIL clear_outputs: got %h want 0", obs_all);
        end
        for (int i = 1; i <= 70; i++) begin
            tick(0, 0, 1, 0);
            n_checks++;
            if (pos_b !== (i == TH_BIG)) begin
                n_fail++;
                $display("FAIL clear_next_pulse tick %0d: got %b want %0d", i, pos_b, i == TH_BIG);
            end
            n_checks++;
            if (obs_all !== exp_all()) begin
                n_fail++;
                $display("FAIL model_clear tick %0d: got %h want %h", i, obs_all, exp_all());
            end
        end
    endtask

    task automatic test_mode_switch();
        tick(1, 0, 0, 0);
        for (int i = 1; i <= 20; i++) tick(0, 1, 1, 0);
        tick(0, 0, 0, 0);
        n_checks++;
        if ({freq_b, freq_s} !== 32'd0) begin
            n_fail++;
            $display("FAIL mode_switch_freq: got %0d/%0d want 0", freq_b, freq_s);
        end
        for (int i = 1; i <= 80; i++) begin
            tick(0, 0, 1, 0);
            n_checks++;
            if (obs_all !== exp_all()) begin
                n_fail++;
                $display("FAIL model_switch tick %0d: got %h want %h", i, obs_all, exp_all());
            end
        end
    endtask

    task automatic test_reset_mid_pulse();
        tick(1, 0, 0, 0);
        for (int i = 1; i <= 4; i++) tick(0, 0, 0, 1);
        n_checks++;
        if (neg_s !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_pulse_pre: got neg=%b want 1", neg_s);
        end
        #2;
        reset_i = 1'b1;
        #1;
        n_checks++;
        if (obs_all !== 38'd0) begin
            n_fail++;
            $display("FAIL reset_async_drop: got %h want 0", obs_all);
        end
        repeat (2) @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        m_big = zero_model();
        m_small = zero_model();
    endtask

    task automatic test_random();
        bit mode = 0;
        for (int i = 1; i <= 3000; i++) begin
            if ($urandom_range(49) == 0) mode = ~mode;
            tick(($urandom_range(99) == 0), mode, ($urandom_range(3) != 0), ($urandom_range(2) == 0));
            n_checks++;
            if (obs_all !== exp_all()) begin
                n_fail++;
                $display("FAIL model_random tick %0d: got %h want %h", i, obs_all, exp_all());
            end
        end
    endtask

    task automatic test_saturation();
        tick(1, 0, 0, 0);
        for (int i = 1; i <= INT_LIM + 40; i++) begin
            tick(0, 1, 1, 0);
            n_checks++;
            if (obs_all !== exp_all()) begin
                n_fail++;
                $display("FAIL model_saturation tick %0d: got %h want %h", i, obs_all, exp_all());
            end
        end
        n_checks++;
        if (freq_b !== 16'd32767) begin
            n_fail++;
            $display("FAIL int_saturated: got %0d want 32767", freq_b);
        end
        tick(0, 1, 0, 1);
        n_checks++;
        if (freq_b !== 16'd32766) begin
            n_fail++;
            $display("FAIL int_unsaturate: got %0d want 32766", freq_b);
        end
    endtask

    initial begin
        test_reset();
        test_mode0_forwarding();
        test_holdoff();
        test_pi_ramp();
        test_both_inputs();
        test_clear();
        test_mode_switch();
        test_reset_mid_pulse();
        test_random();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
